branch_seq_ctrl: RTL and testbench
==================================

Name: branch_seq_ctrl

Overview:
Multi-cycle controller that sequences instruction fetch, register read, branch compare and PC update around the single-cycle branch datapath (PC+4, sign-extended offset <<2, reg1-reg2 zero test). It owns the architectural PC register and talks to instruction memory through a req/ready handshake. It also issues register-file read addresses and resolves BEQ, BNE, J and fall-through instructions. It sits between instruction memory, the register file and the PC/branch datapath in the multi-cycle CPU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be a multiple of 4
CNT_W, 16, width of the saturating branch/taken counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = keep executing, 0 = stop at the next instruction boundary
imem_req  output  1  fetch request; held until accepted
imem_addr  output  32  fetch address (= pc)
imem_ready  input  1  fetch accept; imem_rdata is valid in the same cycle
imem_rdata  input  32  fetched instruction
rf_raddr1  output  5  rs field of the latched instruction
rf_raddr2  output  5  rt field of the latched instruction
rf_rdata1  input  32  rs data, valid one cycle after the address
rf_rdata2  input  32  rt data, valid one cycle after the address
pc  output  32  architectural PC
retire  output  1  one-cycle pulse when the PC is updated
branch_taken  output  1  valid with retire; 1 = redirect (taken BEQ/BNE or J)
busy  output  1  1 in any state other than IDLE
branch_cnt  output  CNT_W  count of BEQ and BNE instructions retired
taken_cnt  output  CNT_W  count of taken BEQ/BNE instructions

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - imem_req, retire, branch_taken, busy = 0.
  - rf_raddr1/2 = 0; instruction register = 0; both counters = 0.
  - Asserting reset mid-operation discards the in-flight instruction with no retire.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE.
- IDLE -> FETCH when run=1.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1, latch imem_rdata into the instruction register and go to DECODE.
  - Stays in FETCH indefinitely while imem_ready=0; run is ignored once a request is outstanding.
- DECODE:
  - rf_raddr1=instr[25:21], rf_raddr2=instr[20:16].
  - Addresses are registered, so they stay stable through EXEC.
- EXEC:
  - rf_rdata1/2 are valid this cycle.
  - Opcode instr[31:26] decode:
    - 6'h04 BEQ: taken = zero.
    - 6'h05 BNE: taken = ~zero.
    - 6'h02 J: taken = 1, target = {pc_plus4[31:28], instr[25:0], 2'b00}.
    - Any other opcode: taken = 0.
  - For BEQ/BNE, zero and the branch target come from the datapath submodule (PC+4 + sext(imm)<<2); for J the target is the one above.
  - Latch next_pc and taken; go to UPDATE.
- UPDATE:
  - pc <= next_pc; retire=1 for exactly this cycle; branch_taken=taken.
  - branch_cnt increments for BEQ/BNE; taken_cnt increments for taken BEQ/BNE. J is not counted.
  - Counters saturate at all-ones.
  - Next state is FETCH if run=1, else IDLE.
- Latency: imem_ready accepted in cycle N -> retire in cycle N+3 -> next imem_req in cycle N+4. Minimum 4 cycles per instruction.
- Arithmetic is 32-bit modulo:
  - PC+4 from 32'hFFFF_FFFC wraps to 0.
  - A negative offset below 0 wraps.
  - The PC stays 4-aligned by construction.
- run deasserted during DECODE or EXEC: the instruction still completes and retires, then the block goes to IDLE.
- branch_taken=0 whenever retire=0.

Decomposition:
- Shared package/header holds:
  - opcode constants OP_BEQ=6'h04, OP_BNE=6'h05, OP_J=6'h02;
  - state encodings;
  - field-position constants (opcode, rs, rt, imm, jump target).
- One sub-module: the existing branch datapath, instantiated once.
  - Inputs: PC=pc, reg1/reg2=rf_rdata, imm=instr[15:0], Branch=1.
  - The controller uses its Zero and nextPC (branch_addr when zero).
  - For BNE and non-taken cases the controller selects PC+4 itself.

Test Plan:
- Reset with RESET_PC=32'h100, run=1, imem_ready=1, instr=32'h0000_0000 -> imem_addr 0x100, then 0x104, 0x108; a retire pulse every 4 cycles; branch_taken=0; counters stay 0.
- pc=0x200, BEQ rs=1 rt=2, imm=16'h0003, rf_rdata1=rf_rdata2=5 -> pc=0x210, branch_taken=1, branch_cnt=1, taken_cnt=1. The same with rdata 5 vs 6 -> pc=0x204, taken_cnt unchanged.
- pc=0x200, BNE imm=16'hFFFE, rdata 1 vs 2 -> pc=0x1FC, taken=1. At pc=0x4 with imm=16'hFFFC -> pc wraps to 32'hFFFF_FFF8.
- pc=0x1000_0040, J target 26'h0000100 -> pc=0x1000_0400, branch_taken=1, branch_cnt unchanged.
- imem_ready held 0 for 7 cycles in FETCH -> imem_req stays 1 with stable address, no retire; run dropped in EXEC -> the instruction retires, then IDLE with busy=0.
- Assert rst_n=0 during EXEC -> pc returns to RESET_PC immediately with no retire pulse. Separately, force branch_cnt to all-ones (CNT_W=4, 16 branches) -> it holds at 4'hF.

Source files
------------

// File: rtl/branch_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_seq_ctrl_pkg
// Brief    : Opcodes, instruction field positions and FSM states for the
//            branch sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package branch_seq_ctrl_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int JT_MSB  = 25;
  localparam int JT_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_seq_ctrl_dp.sv
`default_nettype none
// ============================================================================
// Module   : branch_seq_ctrl_dp
// Brief    : Single-cycle branch datapath: PC+4, sext(imm)<<2 target and
//            reg1/reg2 equality test.
// Revision : 1.0 - initial release
// ============================================================================
module branch_seq_ctrl_dp (
  input  logic [31:0] pc,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [15:0] imm,
  input  logic        branch,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_addr,
  output logic [31:0] next_pc
);

  logic [31:0] w_offset;

  assign w_offset    = {{14{imm[15]}}, imm, 2'b00};
  assign pc_plus4    = pc + 32'd4;
  assign branch_addr = pc_plus4 + w_offset;
  assign zero        = ((reg1 - reg2) == 32'd0);
  assign next_pc     = (branch && zero) ? branch_addr : pc_plus4;

endmodule
`default_nettype wire

// File: rtl/branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_seq_ctrl
// Brief    : Multi-cycle fetch/decode/exec/update sequencer owning the PC and
//            resolving BEQ, BNE, J and fall-through instructions.
// Revision : 1.0 - initial release
// ============================================================================
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  output logic [31:0]      pc,
  output logic             retire,
  output logic             branch_taken,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_next_pc;
  logic             r_taken;
  logic             r_is_branch;
  logic [4:0]       r_raddr1;
  logic [4:0]       r_raddr2;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_zero;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_branch_addr;
  logic [31:0]      w_dp_next_pc;
  logic [5:0]       w_opcode;
  logic             w_exec_taken;
  logic             w_exec_is_branch;
  logic [31:0]      w_exec_target;

  branch_seq_ctrl_dp u_dp (
    .pc          (r_pc),
    .reg1        (rf_rdata1),
    .reg2        (rf_rdata2),
    .imm         (r_instr[IMM_MSB:IMM_LSB]),
    .branch      (1'b1),
    .zero        (w_zero),
    .pc_plus4    (w_pc_plus4),
    .branch_addr (w_branch_addr),
    .next_pc     (w_dp_next_pc)
  );

  assign w_opcode = r_instr[OPC_MSB:OPC_LSB];

  // The datapath only redirects on zero, so BNE picks the branch target itself
  always_comb begin
    w_exec_taken     = 1'b0;
    w_exec_is_branch = 1'b0;
    w_exec_target    = w_pc_plus4;
    case (w_opcode)
      OP_BEQ: begin
        w_exec_is_branch = 1'b1;
        w_exec_taken     = w_zero;
        w_exec_target    = w_dp_next_pc;
      end
      OP_BNE: begin
        w_exec_is_branch = 1'b1;
        w_exec_taken     = ~w_zero;
        w_exec_target    = w_zero ? w_pc_plus4 : w_branch_addr;
      end
      OP_J: begin
        w_exec_taken  = 1'b1;
        w_exec_target = {w_pc_plus4[31:28], r_instr[JT_MSB:JT_LSB], 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_ready) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC:   w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = run ? ST_FETCH : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= 32'd0;
      r_next_pc    <= RESET_PC;
      r_taken      <= 1'b0;
      r_is_branch  <= 1'b0;
      r_raddr1     <= 5'd0;
      r_raddr2     <= 5'd0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Register addresses load with the instruction so read data lands in EXEC
      if (r_state == ST_FETCH && imem_ready) begin
        r_instr  <= imem_rdata;
        r_raddr1 <= imem_rdata[RS_MSB:RS_LSB];
        r_raddr2 <= imem_rdata[RT_MSB:RT_LSB];
      end
      if (r_state == ST_EXEC) begin
        r_next_pc   <= w_exec_target;
        r_taken     <= w_exec_taken;
        r_is_branch <= w_exec_is_branch;
      end
      if (r_state == ST_UPDATE) begin
        r_pc <= r_next_pc;
        if (r_is_branch && (r_branch_cnt != {CNT_W{1'b1}}))
          r_branch_cnt <= r_branch_cnt + CNT_W'(1);
        if (r_is_branch && r_taken && (r_taken_cnt != {CNT_W{1'b1}}))
          r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign imem_req     = (r_state == ST_FETCH);
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign rf_raddr1    = r_raddr1;
  assign rf_raddr2    = r_raddr2;
  assign retire       = (r_state == ST_UPDATE);
  assign branch_taken = retire & r_taken;
  assign busy         = (r_state != ST_IDLE);
  assign branch_cnt   = r_branch_cnt;
  assign taken_cnt    = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_seq_ctrl
// Brief    : Directed self-checking bench for branch_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run_a, run_b, imem_ready, sel;
  logic [31:0] imem_rdata, r1v, r2v;

  logic        req_a, ret_a, bt_a, busy_a;
  logic [31:0] addr_a, pc_a, rd1_a, rd2_a;
  logic [4:0]  ra1_a, ra2_a;
  logic [15:0] bcnt_a, tcnt_a;

  logic        req_b, ret_b, bt_b, busy_b;
  logic [31:0] addr_b, pc_b, rd1_b, rd2_b;
  logic [4:0]  ra1_b, ra2_b;
  logic [3:0]  bcnt_b, tcnt_b;

  branch_seq_ctrl #(.RESET_PC(32'h0000_0100), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .imem_req(req_a), .imem_addr(addr_a),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .rf_raddr1(ra1_a), .rf_raddr2(ra2_a),
    .rf_rdata1(rd1_a), .rf_rdata2(rd2_a), .pc(pc_a), .retire(ret_a), .branch_taken(bt_a),
    .busy(busy_a), .branch_cnt(bcnt_a), .taken_cnt(tcnt_a)
  );

  branch_seq_ctrl #(.RESET_PC(32'h1000_0040), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .rf_raddr1(ra1_b), .rf_raddr2(ra2_b),
    .rf_rdata1(rd1_b), .rf_rdata2(rd2_b), .pc(pc_b), .retire(ret_b), .branch_taken(bt_b),
    .busy(busy_b), .branch_cnt(bcnt_b), .taken_cnt(tcnt_b)
  );

  // Register file model: only r1 and r2 hold data, one-cycle read latency
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    if (a == 5'd1) return r1v;
    else if (a == 5'd2) return r2v;
    else return 32'd0;
  endfunction

  always_ff @(posedge clk) begin
    rd1_a <= rf_val(ra1_a);
    rd2_a <= rf_val(ra2_a);
    rd1_b <= rf_val(ra1_b);
    rd2_b <= rf_val(ra2_b);
  end

  wire        obs_req  = sel ? req_b  : req_a;
  wire [31:0] obs_addr = sel ? addr_b : addr_a;
  wire        obs_ret  = sel ? ret_b  : ret_a;
  wire        obs_bt   = sel ? bt_b   : bt_a;
  wire [31:0] obs_pc   = sel ? pc_b   : pc_a;
  wire [15:0] obs_bcnt = sel ? {12'd0, bcnt_b} : bcnt_a;
  wire [15:0] obs_tcnt = sel ? {12'd0, tcnt_b} : tcnt_a;

  int checks = 0;
  int errors = 0;
  int bt_glitch = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Fetch one instruction on the selected DUT and follow it to retirement
  task automatic do_instr(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                          output logic [31:0] f_addr, output logic tk, output int lat,
                          output logic [31:0] new_pc, output logic ok);
    int n;
    ok = 1'b1; tk = 1'b0; lat = 0; f_addr = 32'hx; new_pc = 32'hx;
    n = 0;
    @(negedge clk);
    while (!obs_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!obs_req) begin
      ok = 1'b0;
      return;
    end
    f_addr = obs_addr;
    r1v = d1;
    r2v = d2;
    imem_rdata = ins;
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (obs_bt && !obs_ret) bt_glitch++;
      if (obs_ret) break;
    end
    if (!obs_ret) ok = 1'b0;
    tk = obs_bt;
    @(negedge clk);
    new_pc = obs_pc;
    if (obs_ret) ok = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] f_addr;
    logic [31:0] exp_pc;
    logic        exp_tk;
    logic [15:0] exp_b;
    logic [15:0] exp_t;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] fa, input logic [31:0] epc, input logic tk,
                              input logic [15:0] b, input logic [15:0] t);
    vec_t v;
    v.ins = ins; v.d1 = d1; v.d2 = d2; v.f_addr = fa; v.exp_pc = epc;
    v.exp_tk = tk; v.exp_b = b; v.exp_t = t;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    logic [31:0] fa, npc;
    logic        tk, ok;
    int          lat, n, bad;

    rst_n = 1'b0; run_a = 1'b0; run_b = 1'b0; sel = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'd0; r1v = 32'd0; r2v = 32'd0;

    //            instr          d1  d2  fetch addr     new pc         tk  bcnt tcnt
    vecs[0]  = mk(32'h0000_0000, 0,  0,  32'h0000_0100, 32'h0000_0104, 0,  0,   0);
    vecs[1]  = mk(32'h0000_0000, 0,  0,  32'h0000_0104, 32'h0000_0108, 0,  0,   0);
    vecs[2]  = mk(32'h0000_0000, 0,  0,  32'h0000_0108, 32'h0000_010C, 0,  0,   0);
    vecs[3]  = mk(32'h0800_0080, 0,  0,  32'h0000_010C, 32'h0000_0200, 1,  0,   0);
    vecs[4]  = mk(32'h1022_0003, 5,  5,  32'h0000_0200, 32'h0000_0210, 1,  1,   1);
    vecs[5]  = mk(32'h0800_0080, 0,  0,  32'h0000_0210, 32'h0000_0200, 1,  1,   1);
    vecs[6]  = mk(32'h1022_0003, 5,  6,  32'h0000_0200, 32'h0000_0204, 0,  2,   1);
    vecs[7]  = mk(32'h0800_0080, 0,  0,  32'h0000_0204, 32'h0000_0200, 1,  2,   1);
    vecs[8]  = mk(32'h1422_FFFE, 1,  2,  32'h0000_0200, 32'h0000_01FC, 1,  3,   2);
    vecs[9]  = mk(32'h0800_0001, 0,  0,  32'h0000_01FC, 32'h0000_0004, 1,  3,   2);
    vecs[10] = mk(32'h1422_FFFC, 1,  2,  32'h0000_0004, 32'hFFFF_FFF8, 1,  4,   3);
    vecs[11] = mk(32'h0000_0000, 0,  0,  32'hFFFF_FFF8, 32'hFFFF_FFFC, 0,  4,   3);
    vecs[12] = mk(32'h0000_0000, 0,  0,  32'hFFFF_FFFC, 32'h0000_0000, 0,  4,   3);
    vecs[13] = mk(32'h1422_0005, 7,  7,  32'h0000_0000, 32'h0000_0004, 0,  5,   3);
    vecs[14] = mk(32'h0800_0080, 0,  0,  32'h0000_0004, 32'h0000_0200, 1,  5,   3);
    vecs[15] = mk(32'h2022_FFFF, 3,  3,  32'h0000_0200, 32'h0000_0204, 0,  5,   3);

    #12;
    chk("reset pc", pc_a, 32'h0000_0100);
    chk("reset pc_b", pc_b, 32'h1000_0040);
    chk("reset req", {31'd0, req_a}, 32'd0);
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset retire", {31'd0, ret_a}, 32'd0);
    chk("reset taken", {31'd0, bt_a}, 32'd0);
    chk("reset raddr", {22'd0, ra1_a, ra2_a}, 32'd0);
    chk("reset cnts", {bcnt_a, tcnt_a}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    run_a = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_instr(vecs[i].ins, vecs[i].d1, vecs[i].d2, fa, tk, lat, npc, ok);
      chk($sformatf("v%0d handshake", i), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d fetch addr", i), fa, vecs[i].f_addr);
      chk($sformatf("v%0d latency", i), lat, 32'd3);
      chk($sformatf("v%0d taken", i), {31'd0, tk}, {31'd0, vecs[i].exp_tk});
      chk($sformatf("v%0d pc", i), npc, vecs[i].exp_pc);
      chk($sformatf("v%0d branch_cnt", i), {16'd0, obs_bcnt}, {16'd0, vecs[i].exp_b});
      chk($sformatf("v%0d taken_cnt", i), {16'd0, obs_tcnt}, {16'd0, vecs[i].exp_t});
    end

    // Fetch stall for 7 cycles, then drop run during EXEC
    n = 0;
    @(negedge clk);
    while (!req_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    fa = addr_a;
    chk("stall addr", fa, 32'h0000_0204);
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (!req_a || addr_a !== fa || ret_a) bad++;
    end
    chk("stall hold", bad, 32'd0);
    imem_rdata = 32'h0000_0000;
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    @(negedge clk);
    chk("decode busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    run_a = 1'b0;
    @(negedge clk);
    chk("rundrop retire", {31'd0, ret_a}, 32'd1);
    @(negedge clk);
    chk("rundrop busy", {31'd0, busy_a}, 32'd0);
    chk("rundrop req", {31'd0, req_a}, 32'd0);
    chk("rundrop pc", pc_a, 32'h0000_0208);
    repeat (3) @(negedge clk);
    chk("idle req", {31'd0, req_a}, 32'd0);

    // Reset asserted while a jump sits in EXEC
    run_a = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst fetch addr", addr_a, 32'h0000_0208);
    imem_rdata = 32'h0800_0080;
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst pc", pc_a, 32'h0000_0100);
    chk("rst busy", {31'd0, busy_a}, 32'd0);
    chk("rst cnt", {bcnt_a, tcnt_a}, 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ret_a || bt_a) bad++;
    end
    chk("rst no retire", bad, 32'd0);
    run_a = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst pc", pc_a, 32'h0000_0100);

    // Jump with upper PC bits set, then counter saturation on the 4-bit DUT
    sel = 1'b1;
    run_b = 1'b1;
    do_instr(32'h0800_0100, 0, 0, fa, tk, lat, npc, ok);
    chk("j hi handshake", {31'd0, ok}, 32'd1);
    chk("j hi fetch addr", fa, 32'h1000_0040);
    chk("j hi pc", npc, 32'h1000_0400);
    chk("j hi taken", {31'd0, tk}, 32'd1);
    chk("j hi branch_cnt", {16'd0, obs_bcnt}, 32'd0);
    for (int k = 1; k <= 17; k++) begin
      do_instr(32'h1022_0000, 9, 9, fa, tk, lat, npc, ok);
      chk($sformatf("sat%0d handshake", k), {31'd0, ok}, 32'd1);
      chk($sformatf("sat%0d pc", k), npc, 32'h1000_0400 + 32'(4 * k));
      chk($sformatf("sat%0d taken", k), {31'd0, tk}, 32'd1);
      chk($sformatf("sat%0d branch_cnt", k), {16'd0, obs_bcnt}, (k > 15) ? 32'd15 : 32'(k));
      chk($sformatf("sat%0d taken_cnt", k), {16'd0, obs_tcnt}, (k > 15) ? 32'd15 : 32'(k));
    end
    run_b = 1'b0;
    chk("taken without retire", bt_glitch, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
